// File: rtl/axis_eth_preamble_insert_pkg.sv
// Shared Ethernet framing constants and types for the byte-wide TX path.
// The GMII/XGMII TX adapters reuse the preamble/SFD constants.
package axis_eth_preamble_insert_pkg;

   localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;
   localparam int         ETH_MIN_IFG       = 12;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_PAYLOAD,
      ST_IFG
   } pre_state_e;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       user;
   } axis_beat8_t;

endpackage

// File: rtl/axis_skid_reg_8.sv
// Two-register (output + temp) skid buffer for an 8-bit data/last/user stream.
// The producer may only present a beat while m_axis_tready_int_reg is high.
module axis_skid_reg_8
   import axis_eth_preamble_insert_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_tdata,
   input  logic       in_tvalid,
   input  logic       in_tlast,
   input  logic       in_tuser,
   output logic       m_axis_tready_int_reg,
   output logic       m_axis_tready_int_early,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser
);

   axis_beat8_t in_beat;
   axis_beat8_t out_q, out_d, tmp_q, tmp_d;
   logic        out_vld_q, out_vld_d, tmp_vld_q, tmp_vld_d, rdy_q;

   assign in_beat = '{data: in_tdata, last: in_tlast, user: in_tuser};

   // Ready for next cycle if the temp slot is free and the output slot
   // will not be left holding a beat alongside a new one.
   assign m_axis_tready_int_early = m_axis_tready || (!tmp_vld_q && (!out_vld_q || !in_tvalid));

   always_comb begin
      out_d     = out_q;
      out_vld_d = out_vld_q;
      tmp_d     = tmp_q;
      tmp_vld_d = tmp_vld_q;
      if (rdy_q) begin
         if (m_axis_tready || !out_vld_q) begin
            out_d     = in_beat;
            out_vld_d = in_tvalid;
         end else begin
            tmp_d     = in_beat;
            tmp_vld_d = in_tvalid;
         end
      end else if (m_axis_tready) begin
         out_d     = tmp_q;
         out_vld_d = tmp_vld_q;
         tmp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
         tmp_q     <= '0;
         tmp_vld_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         tmp_q     <= tmp_d;
         tmp_vld_q <= tmp_vld_d;
         rdy_q     <= m_axis_tready_int_early;
      end
   end

   assign m_axis_tready_int_reg = rdy_q;
   assign m_axis_tdata          = out_q.data;
   assign m_axis_tlast          = out_q.last;
   assign m_axis_tuser          = out_q.user;
   assign m_axis_tvalid         = out_vld_q;

endmodule

// File: rtl/axis_eth_preamble_insert.sv
// Prefixes each frame with PREAMBLE_LEN x 0x55 + 0xD5 and enforces MIN_IFG
// idle output cycles between a frame's last byte and the next preamble.
module axis_eth_preamble_insert
   import axis_eth_preamble_insert_pkg::*;
#(
   parameter int MIN_IFG      = ETH_MIN_IFG,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       start_packet,
   output logic       busy
);

   localparam logic [3:0] PRE_LEN = 4'(PREAMBLE_LEN);
   localparam logic [7:0] IFG_LD  = 8'(MIN_IFG);

   pre_state_e state_q, state_d;
   logic [3:0] ptr_q, ptr_d;
   logic [7:0] ifg_cnt_q, ifg_cnt_d;
   logic       s_axis_tready_q, s_axis_tready_d;
   logic       start_packet_q, start_packet_d;
   logic       busy_q;

   logic [7:0] int_tdata;
   logic       int_tvalid, int_tlast, int_tuser;
   logic       m_axis_tready_int_reg, m_axis_tready_int_early;

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      ifg_cnt_d       = ifg_cnt_q;
      s_axis_tready_d = 1'b0;
      start_packet_d  = 1'b0;
      int_tdata       = 8'h00;
      int_tvalid      = 1'b0;
      int_tlast       = 1'b0;
      int_tuser       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s_axis_tvalid && m_axis_tready_int_reg) begin
               int_tdata  = ETH_PREAMBLE_BYTE;
               int_tvalid = 1'b1;
               ptr_d      = 4'd1;
               state_d    = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (m_axis_tready_int_reg) begin
               int_tvalid = 1'b1;
               ptr_d      = ptr_q + 4'd1;
               if (ptr_q < PRE_LEN) begin
                  int_tdata = ETH_PREAMBLE_BYTE;
               end else begin
                  int_tdata       = ETH_SFD_BYTE;
                  start_packet_d  = 1'b1;
                  s_axis_tready_d = m_axis_tready_int_early;
                  ptr_d           = 4'd0;
                  state_d         = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            s_axis_tready_d = m_axis_tready_int_early;
            int_tdata       = s_axis_tdata;
            int_tvalid      = s_axis_tvalid && s_axis_tready_q;
            int_tlast       = s_axis_tlast && int_tvalid;
            int_tuser       = s_axis_tuser && int_tvalid && s_axis_tlast;
            if (int_tvalid && s_axis_tlast) begin
               s_axis_tready_d = 1'b0;
               if (MIN_IFG == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  ifg_cnt_d = IFG_LD;
                  state_d   = ST_IFG;
               end
            end
         end
         ST_IFG: begin
            // Only idle symbols actually leaving the port count toward the gap.
            if (!m_axis_tvalid && m_axis_tready && ifg_cnt_q != 8'd0) begin
               ifg_cnt_d = ifg_cnt_q - 8'd1;
               if (ifg_cnt_q == 8'd1) begin
                  state_d = ST_IDLE;
                  // Final gap tick doubles as the IDLE launch cycle, so a waiting
                  // frame's first 0x55 lands right after the last idle symbol.
                  if (s_axis_tvalid && m_axis_tready_int_reg) begin
                     int_tdata  = ETH_PREAMBLE_BYTE;
                     int_tvalid = 1'b1;
                     ptr_d      = 4'd1;
                     state_d    = ST_PREAMBLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         ptr_q           <= 4'd0;
         ifg_cnt_q       <= 8'd0;
         s_axis_tready_q <= 1'b0;
         start_packet_q  <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         ifg_cnt_q       <= ifg_cnt_d;
         s_axis_tready_q <= s_axis_tready_d;
         start_packet_q  <= start_packet_d;
         busy_q          <= (state_d != ST_IDLE);
      end
   end

   assign s_axis_tready = s_axis_tready_q;
   assign start_packet  = start_packet_q;
   assign busy          = busy_q;

   axis_skid_reg_8 u_skid (
      .clk                     (clk),
      .rst                     (rst),
      .in_tdata                (int_tdata),
      .in_tvalid               (int_tvalid),
      .in_tlast                (int_tlast),
      .in_tuser                (int_tuser),
      .m_axis_tready_int_reg   (m_axis_tready_int_reg),
      .m_axis_tready_int_early (m_axis_tready_int_early),
      .m_axis_tdata            (m_axis_tdata),
      .m_axis_tvalid           (m_axis_tvalid),
      .m_axis_tready           (m_axis_tready),
      .m_axis_tlast            (m_axis_tlast),
      .m_axis_tuser            (m_axis_tuser)
   );

endmodule
